// File: rtl/open_nic_file_tools.sv
// Shared types for the capture sink: default stream widths, the captured
// record layout held in the record FIFO, and the two FSM state encodings.
package open_nic_file_tools;

    localparam int CAP_W_DATA = 512;
    localparam int CAP_W_KEEP = CAP_W_DATA / 8;

    typedef enum logic {
        PAT_ON  = 1'b0,
        PAT_OFF = 1'b1
    } pat_state_t;

    typedef enum logic {
        PKT_IDLE = 1'b0,
        PKT_IN   = 1'b1
    } pkt_state_t;

    // One captured beat plus its timing and position metadata
    typedef struct packed {
        logic [CAP_W_DATA-1:0] tdata;
        logic [CAP_W_KEEP-1:0] tkeep;
        logic                  tlast;
        logic [31:0]           cycle;
        logic [15:0]           gap;
        logic [15:0]           pkt_idx;
        logic [15:0]           beat_idx;
    } capture_rec_t;

endpackage

// File: rtl/capture_fifo.sv
// Synchronous first-word-fall-through FIFO of capture records.
// full/empty are registered; a push is ignored while full even if a pop
// happens in the same cycle. DEPTH must be a power of 2, at least 2.
module capture_fifo
    import open_nic_file_tools::*;
#(
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  capture_rec_t din,
    input  logic         pop,
    output capture_rec_t dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    capture_rec_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [AW:0]    count_r;
    logic           full_r;
    logic           empty_r;
    logic           do_push_s;
    logic           do_pop_s;
    logic [AW:0]    count_next_s;

    // Qualify push/pop against the registered flags and compute next occupancy
    always_comb begin
        do_push_s    = push && !full_r;
        do_pop_s     = pop && !empty_r;
        count_next_s = count_r;
        if (do_push_s && !do_pop_s) begin
            count_next_s = count_r + (AW+1)'(1);
        end else if (do_pop_s && !do_push_s) begin
            count_next_s = count_r - (AW+1)'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Pointers, occupancy and registered full/empty flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == (AW+1)'(DEPTH));
            empty_r <= (count_next_s == {(AW+1){1'b0}});
        end
    end

    // Record storage; contents need no reset because empty gates the output
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem[wr_ptr_r] <= din;
        end
    end

    assign dout  = mem[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/axis_capture_sink.sv
// AXI-Stream capture sink: applies a programmable ON/OFF backpressure
// pattern, stamps every accepted beat with cycle, gap and packet position,
// and queues the records in a FWFT FIFO for the consumer.
// Optional keep checking is compiled in with AXIS_CAPTURE_KEEP_CHECK_EN.
// W_DATA may not exceed the package default (records carry CAP_W_DATA bits).
module axis_capture_sink
    import open_nic_file_tools::*;
#(
    parameter int W_DATA     = CAP_W_DATA,
    parameter int W_KEEP     = W_DATA / 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              axis_aclk,
    input  logic              axis_areset,
    input  logic              s_axis_tvalid,
    input  logic [W_DATA-1:0] s_axis_tdata,
    input  logic [W_KEEP-1:0] s_axis_tkeep,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    input  logic [15:0]       cfg_on_cycles,
    input  logic [15:0]       cfg_off_cycles,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [W_DATA-1:0] rec_tdata,
    output logic [W_KEEP-1:0] rec_tkeep,
    output logic              rec_tlast,
    output logic [31:0]       rec_cycle,
    output logic [15:0]       rec_gap,
    output logic [15:0]       rec_pkt_idx,
    output logic [15:0]       rec_beat_idx,
    output logic [31:0]       pkt_count,
    output logic              err_keep
);

    pat_state_t   pat_state_r;
    logic [15:0]  pat_cnt_r;
    logic         pat_entry_r;
    logic [15:0]  on_len_r;
    logic [15:0]  off_len_r;
    logic [15:0]  on_len_s;
    logic [15:0]  off_len_s;
    logic [16:0]  pat_cnt_inc_s;

    pkt_state_t   pkt_state_r;
    logic [15:0]  beat_r;
    logic [15:0]  pkt_idx_r;
    logic [31:0]  pkt_count_r;
    logic [15:0]  cur_beat_s;

    logic [31:0]  cycle_r;
    logic [15:0]  gap_cnt_r;
    logic         have_prev_r;

    logic         fifo_full_s;
    logic         fifo_empty_s;
    logic         accept_s;
    logic         ready_s;
    capture_rec_t rec_in_s;
    capture_rec_t rec_out_s;

    // Config is taken live on the entry cycle of a state and held afterwards
    always_comb begin
        if (pat_entry_r) begin
            on_len_s  = cfg_on_cycles;
            off_len_s = cfg_off_cycles;
        end else begin
            on_len_s  = on_len_r;
            off_len_s = off_len_r;
        end
        pat_cnt_inc_s = {1'b0, pat_cnt_r} + 17'd1;
    end

    // Pattern FSM: ON window of on_len cycles, OFF window of off_len cycles
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            pat_state_r <= PAT_ON;
            pat_cnt_r   <= 16'd0;
            pat_entry_r <= 1'b1;
            on_len_r    <= 16'd0;
            off_len_r   <= 16'd0;
        end else begin
            on_len_r  <= on_len_s;
            off_len_r <= off_len_s;
            case (pat_state_r)
                PAT_ON: begin
                    if (off_len_s == 16'd0) begin
                        pat_cnt_r   <= 16'd0;
                        pat_entry_r <= 1'b0;
                    end else if (pat_cnt_inc_s >= {1'b0, on_len_s}) begin
                        pat_state_r <= PAT_OFF;
                        pat_cnt_r   <= 16'd0;
                        pat_entry_r <= 1'b1;
                    end else begin
                        pat_cnt_r   <= pat_cnt_inc_s[15:0];
                        pat_entry_r <= 1'b0;
                    end
                end
                PAT_OFF: begin
                    if (on_len_s == 16'd0) begin
                        pat_cnt_r   <= 16'd0;
                        pat_entry_r <= 1'b0;
                    end else if (pat_cnt_inc_s >= {1'b0, off_len_s}) begin
                        pat_state_r <= PAT_ON;
                        pat_cnt_r   <= 16'd0;
                        pat_entry_r <= 1'b1;
                    end else begin
                        pat_cnt_r   <= pat_cnt_inc_s[15:0];
                        pat_entry_r <= 1'b0;
                    end
                end
                default: begin
                    pat_state_r <= PAT_ON;
                    pat_cnt_r   <= 16'd0;
                    pat_entry_r <= 1'b1;
                end
            endcase
        end
    end

    // Ready comes only from registered state, forced low while in reset
    always_comb begin
        if (axis_areset) begin
            ready_s = 1'b0;
        end else begin
            ready_s = (pat_state_r == PAT_ON) && !fifo_full_s;
        end
        accept_s = s_axis_tvalid && ready_s;
        if (pkt_state_r == PKT_IDLE) begin
            cur_beat_s = 16'd0;
        end else begin
            cur_beat_s = beat_r;
        end
    end

    // Free-running cycle stamp and saturating distance since the last accept
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            cycle_r     <= 32'd0;
            gap_cnt_r   <= 16'd0;
            have_prev_r <= 1'b0;
        end else begin
            cycle_r <= cycle_r + 32'd1;
            if (accept_s) begin
                gap_cnt_r   <= 16'd1;
                have_prev_r <= 1'b1;
            end else if (gap_cnt_r != 16'hFFFF) begin
                gap_cnt_r <= gap_cnt_r + 16'd1;
            end else begin
                gap_cnt_r <= gap_cnt_r;
            end
        end
    end

    // Packet FSM: tracks beat position and counts completed packets
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            pkt_state_r <= PKT_IDLE;
            beat_r      <= 16'd0;
            pkt_idx_r   <= 16'd0;
            pkt_count_r <= 32'd0;
        end else if (accept_s) begin
            if (s_axis_tlast) begin
                pkt_state_r <= PKT_IDLE;
                beat_r      <= 16'd0;
                pkt_idx_r   <= pkt_idx_r + 16'd1;
                if (pkt_count_r != 32'hFFFF_FFFF) begin
                    pkt_count_r <= pkt_count_r + 32'd1;
                end
            end else begin
                pkt_state_r <= PKT_IN;
                beat_r      <= cur_beat_s + 16'd1;
            end
        end
    end

    // Assemble the record for the beat being accepted this cycle
    always_comb begin
        rec_in_s          = '{default: 1'b0};
        rec_in_s.tdata    = CAP_W_DATA'(s_axis_tdata);
        rec_in_s.tkeep    = CAP_W_KEEP'(s_axis_tkeep);
        rec_in_s.tlast    = s_axis_tlast;
        rec_in_s.cycle    = cycle_r;
        if (have_prev_r) begin
            rec_in_s.gap = gap_cnt_r;
        end else begin
            rec_in_s.gap = 16'd0;
        end
        rec_in_s.pkt_idx  = pkt_idx_r;
        rec_in_s.beat_idx = cur_beat_s;
    end

    capture_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (axis_aclk),
        .rst   (axis_areset),
        .push  (accept_s),
        .din   (rec_in_s),
        .pop   (rec_ready),
        .dout  (rec_out_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign s_axis_tready = ready_s;
    assign rec_valid     = !fifo_empty_s;
    assign rec_tdata     = rec_out_s.tdata[W_DATA-1:0];
    assign rec_tkeep     = rec_out_s.tkeep[W_KEEP-1:0];
    assign rec_tlast     = rec_out_s.tlast;
    assign rec_cycle     = rec_out_s.cycle;
    assign rec_gap       = rec_out_s.gap;
    assign rec_pkt_idx   = rec_out_s.pkt_idx;
    assign rec_beat_idx  = rec_out_s.beat_idx;
    assign pkt_count     = pkt_count_r;

`ifdef AXIS_CAPTURE_KEEP_CHECK_EN
    logic err_keep_r;

    // Last beats need a non-empty keep packed from bit 0; others need all ones
    function automatic logic keep_bad(input logic [W_KEEP-1:0] keep, input logic last);
        logic contiguous;
        contiguous = ((keep & (keep + W_KEEP'(1))) == {W_KEEP{1'b0}}) &&
                     (keep != {W_KEEP{1'b0}});
        if (last) begin
            keep_bad = !contiguous;
        end else begin
            keep_bad = (keep != {W_KEEP{1'b1}});
        end
    endfunction

    // Sticky keep error, cleared only by reset
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            err_keep_r <= 1'b0;
        end else if (accept_s && keep_bad(s_axis_tkeep, s_axis_tlast)) begin
            err_keep_r <= 1'b1;
        end
    end

    assign err_keep = err_keep_r;
`else
    assign err_keep = 1'b0;
`endif

endmodule

// File: tb/tb_axis_capture_sink.sv
// Randomised and directed bench for axis_capture_sink with a queue-based
// reference model of the backpressure pattern, stamping and record FIFO.
module tb_axis_capture_sink;

    localparam int WD    = 32;
    localparam int WK    = 4;
    localparam int DEPTH = 4;
`ifdef AXIS_CAPTURE_KEEP_CHECK_EN
    localparam bit KEEP_EN = 1'b1;
`else
    localparam bit KEEP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [31:0] cyc;
        logic [15:0] gap;
        logic [15:0] pkt;
        logic [15:0] beat;
    } mrec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tvalid = 1'b0;
    logic [WD-1:0] tdata = '0;
    logic [WK-1:0] tkeep = '0;
    logic          tlast = 1'b0;
    logic          tready;
    logic [15:0]   cfg_on = 16'd1;
    logic [15:0]   cfg_off = 16'd0;
    logic          rec_valid;
    logic          rec_ready = 1'b0;
    logic [WD-1:0] rec_tdata;
    logic [WK-1:0] rec_tkeep;
    logic          rec_tlast;
    logic [31:0]   rec_cycle;
    logic [15:0]   rec_gap;
    logic [15:0]   rec_pkt_idx;
    logic [15:0]   rec_beat_idx;
    logic [31:0]   pkt_count;
    logic          err_keep;

    int checks = 0;
    int errors = 0;

    // reference model state
    mrec_t       q[$];
    int unsigned k;
    int          m_on, m_off;
    int unsigned m_pkt, m_beat, m_pkt_count;
    longint      m_last;
    bit          m_have;
    bit          m_err;
    int          acc_seen;

    // observed popped records
    int obs_gap[$];
    int obs_beat[$];
    int obs_pkt[$];
    int obs_cyc[$];

    axis_capture_sink #(.W_DATA(WD), .W_KEEP(WK), .FIFO_DEPTH(DEPTH)) dut (
        .axis_aclk      (clk),
        .axis_areset    (rst),
        .s_axis_tvalid  (tvalid),
        .s_axis_tdata   (tdata),
        .s_axis_tkeep   (tkeep),
        .s_axis_tlast   (tlast),
        .s_axis_tready  (tready),
        .cfg_on_cycles  (cfg_on),
        .cfg_off_cycles (cfg_off),
        .rec_valid      (rec_valid),
        .rec_ready      (rec_ready),
        .rec_tdata      (rec_tdata),
        .rec_tkeep      (rec_tkeep),
        .rec_tlast      (rec_tlast),
        .rec_cycle      (rec_cycle),
        .rec_gap        (rec_gap),
        .rec_pkt_idx    (rec_pkt_idx),
        .rec_beat_idx   (rec_beat_idx),
        .pkt_count      (pkt_count),
        .err_keep       (err_keep)
    );

    always #5 clk = ~clk;

    // window position within the ON/OFF period, counted from reset release
    function automatic bit pat_on(input int unsigned cyc);
        if (m_off == 0) return 1'b1;
        if (m_on == 0) return (cyc == 0);
        return (cyc % (m_on + m_off)) < m_on;
    endfunction

    function automatic bit keep_illegal(input logic [3:0] kp, input logic l);
        if (l) return !(kp == 4'h1 || kp == 4'h3 || kp == 4'h7 || kp == 4'hF);
        return kp != 4'hF;
    endfunction

    task automatic do_reset(input int on_c, input int off_c);
        cfg_on = 16'(on_c);
        cfg_off = 16'(off_c);
        rst = 1'b1;
        tvalid = 1'b0; tlast = 1'b0; tkeep = '0; tdata = '0; rec_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b want 0", tready); end
        checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL rst_rec_valid got %b want 0", rec_valid); end
        checks++; if (err_keep !== 1'b0) begin errors++; $display("FAIL rst_err_keep got %b want 0", err_keep); end
        checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL rst_pkt_count got %0d want 0", pkt_count); end
        @(negedge clk);
        rst = 1'b0;
        k = 0; q.delete(); m_on = on_c; m_off = off_c;
        m_pkt = 0; m_beat = 0; m_pkt_count = 0; m_have = 1'b0; m_last = 0; m_err = 1'b0;
        acc_seen = 0;
        obs_gap.delete(); obs_beat.delete(); obs_pkt.delete(); obs_cyc.delete();
    endtask

    // one clock cycle: drive, compare against the model, advance the model
    task automatic step(input logic v, input logic [31:0] d, input logic [3:0] kp,
                        input logic l, input logic rr);
        mrec_t r;
        bit    exp_ready, exp_valid, acc;
        longint diff;
        tvalid = v; tdata = d; tkeep = kp; tlast = l; rec_ready = rr;
        #1;
        exp_ready = pat_on(k) && (q.size() < DEPTH);
        exp_valid = (q.size() > 0);
        checks++; if (tready !== exp_ready) begin errors++; $display("FAIL tready cyc %0d got %b want %b", k, tready, exp_ready); end
        checks++; if (rec_valid !== exp_valid) begin errors++; $display("FAIL rec_valid cyc %0d got %b want %b", k, rec_valid, exp_valid); end
        if (exp_valid) begin
            checks++;
            if ({rec_tdata, rec_tkeep, rec_tlast, rec_cycle, rec_gap, rec_pkt_idx, rec_beat_idx} !== q[0]) begin
                errors++;
                $display("FAIL record cyc %0d got %h/%h/%b/%0d/%0d/%0d/%0d want %h/%h/%b/%0d/%0d/%0d/%0d", k,
                         rec_tdata, rec_tkeep, rec_tlast, rec_cycle, rec_gap, rec_pkt_idx, rec_beat_idx,
                         q[0].data, q[0].keep, q[0].last, q[0].cyc, q[0].gap, q[0].pkt, q[0].beat);
            end
        end
        checks++; if (pkt_count !== m_pkt_count) begin errors++; $display("FAIL pkt_count cyc %0d got %0d want %0d", k, pkt_count, m_pkt_count); end
        checks++; if (err_keep !== m_err) begin errors++; $display("FAIL err_keep cyc %0d got %b want %b", k, err_keep, m_err); end
        if (rec_valid === 1'b1 && rr) begin
            obs_gap.push_back(int'(rec_gap)); obs_beat.push_back(int'(rec_beat_idx));
            obs_pkt.push_back(int'(rec_pkt_idx)); obs_cyc.push_back(int'(rec_cycle));
        end
        if (tready === 1'b1 && v) acc_seen++;
        // model edge
        if (exp_valid && rr) void'(q.pop_front());
        acc = v && exp_ready;
        if (acc) begin
            r.data = d; r.keep = kp; r.last = l; r.cyc = k;
            diff = longint'(k) - m_last;
            r.gap = !m_have ? 16'd0 : (diff > 65535 ? 16'hFFFF : 16'(diff));
            r.pkt = 16'(m_pkt); r.beat = 16'(m_beat);
            q.push_back(r);
            m_have = 1'b1; m_last = k;
            if (l) begin m_pkt++; m_beat = 0; m_pkt_count++; end
            else m_beat++;
            if (KEEP_EN && keep_illegal(kp, l)) m_err = 1'b1;
        end
        k++;
        @(negedge clk);
    endtask

    task automatic test_reset;
        do_reset(1, 0);
        step(1'b0, 32'd0, 4'h0, 1'b0, 1'b1);
    endtask

    task automatic test_always_ready;
        do_reset(1, 0);
        step(1'b1, $urandom, 4'hF, 1'b0, 1'b1);
        step(1'b1, $urandom, 4'hF, 1'b0, 1'b1);
        step(1'b1, $urandom, 4'hF, 1'b1, 1'b1);
        repeat (3) step(1'b0, 32'd0, 4'h0, 1'b0, 1'b1);
        checks++;
        if (obs_beat.size() != 3) begin errors++; $display("FAIL ar_count got %0d want 3", obs_beat.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (obs_beat[i] != i) begin errors++; $display("FAIL ar_beat%0d got %0d want %0d", i, obs_beat[i], i); end
                checks++; if (obs_gap[i] != (i == 0 ? 0 : 1)) begin errors++; $display("FAIL ar_gap%0d got %0d want %0d", i, obs_gap[i], (i == 0 ? 0 : 1)); end
            end
        end
        checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL ar_pkt_count got %0d want 1", pkt_count); end
    endtask

    task automatic test_backpressure;
        bit pat[5];
        pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset(2, 3);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, $urandom, 4'hF, 1'($urandom_range(0, 1)), 1'b1);
            checks++;
            if (tready !== pat[(i + 1) % 5]) begin errors++; $display("FAIL bp_tready%0d got %b want %b", i + 1, tready, pat[(i + 1) % 5]); end
        end
        step(1'b0, 32'd0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 4'h0, 1'b0, 1'b1);
        checks++; if (obs_cyc.size() != 8) begin errors++; $display("FAIL bp_records got %0d want 8", obs_cyc.size()); end
        foreach (obs_cyc[i]) begin
            checks++; if ((obs_cyc[i] % 5) >= 2) begin errors++; $display("FAIL bp_stamp got %0d want an ON cycle", obs_cyc[i]); end
        end
    endtask

    task automatic test_fifo_full;
        int left;
        do_reset(1, 0);
        left = 6;
        for (int i = 0; i < 8; i++) begin
            step(left > 0, $urandom, 4'hF, 1'b0, 1'b0);
            left = 6 - acc_seen;
        end
        checks++; if (acc_seen != 4) begin errors++; $display("FAIL ff_accepts got %0d want 4", acc_seen); end
        checks++; if (tready !== 1'b0) begin errors++; $display("FAIL ff_tready got %b want 0", tready); end
        for (int p = 0; p < 2; p++) begin
            step(left > 0, $urandom, 4'hF, 1'b0, 1'b1);
            left = 6 - acc_seen;
            repeat (3) begin
                step(left > 0, $urandom, 4'hF, 1'b0, 1'b0);
                left = 6 - acc_seen;
            end
            checks++; if (acc_seen != 5 + p) begin errors++; $display("FAIL ff_pulse%0d got %0d want %0d", p, acc_seen, 5 + p); end
        end
        repeat (6) step(1'b0, 32'd0, 4'h0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_packet;
        do_reset(1, 0);
        step(1'b1, $urandom, 4'hF, 1'b0, 1'b1);
        step(1'b1, $urandom, 4'hF, 1'b0, 1'b1);
        do_reset(1, 0);
        step(1'b1, $urandom, 4'hF, 1'b1, 1'b1);
        repeat (2) step(1'b0, 32'd0, 4'h0, 1'b0, 1'b1);
        checks++;
        if (obs_beat.size() != 1) begin errors++; $display("FAIL rm_count got %0d want 1", obs_beat.size()); end
        else begin
            checks++; if (obs_beat[0] != 0) begin errors++; $display("FAIL rm_beat got %0d want 0", obs_beat[0]); end
            checks++; if (obs_pkt[0] != 0) begin errors++; $display("FAIL rm_pkt got %0d want 0", obs_pkt[0]); end
        end
        checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL rm_pkt_count got %0d want 1", pkt_count); end
    endtask

    task automatic test_keep;
        do_reset(1, 0);
        step(1'b1, $urandom, 4'hE, 1'b0, 1'b1);
        checks++; if (err_keep !== KEEP_EN) begin errors++; $display("FAIL keep_set got %b want %b", err_keep, KEEP_EN); end
        repeat (4) step(1'b1, $urandom, 4'hF, 1'b0, 1'b1);
        checks++; if (err_keep !== KEEP_EN) begin errors++; $display("FAIL keep_hold got %b want %b", err_keep, KEEP_EN); end
    endtask

    task automatic test_gap_saturation;
        do_reset(1, 0);
        step(1'b1, $urandom, 4'hF, 1'b1, 1'b1);
        repeat (70000) step(1'b0, 32'd0, 4'h0, 1'b0, 1'b1);
        step(1'b1, $urandom, 4'hF, 1'b1, 1'b1);
        step(1'b0, 32'd0, 4'h0, 1'b0, 1'b1);
        checks++;
        if (obs_gap.size() != 2) begin errors++; $display("FAIL gs_count got %0d want 2", obs_gap.size()); end
        else if (obs_gap[1] != 65535) begin errors++; $display("FAIL gs_gap got %0d want 65535", obs_gap[1]); end
    endtask

    task automatic test_random;
        logic [3:0] ktab[8];
        ktab = '{4'hF, 4'hF, 4'hF, 4'h7, 4'h3, 4'h1, 4'hE, 4'h0};
        for (int r = 0; r < 3; r++) begin
            do_reset($urandom_range(1, 4), $urandom_range(0, 3));
            for (int i = 0; i < 150; i++) begin
                step(1'($urandom_range(0, 1)), $urandom, ktab[$urandom_range(0, 7)],
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_always_ready();
        test_backpressure();
        test_fifo_full();
        test_reset_mid_packet();
        test_keep();
        test_gap_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_capture_sink.md
AXIS_CAPTURE_SINK -- requirements
Module: axis_capture_sink

Interface
REQ-001 SHALL have parameters: W_DATA, default 512, stream data width; W_KEEP, default W_DATA/8, keep width; FIFO_DEPTH, default 16, record FIFO depth (power of 2, at least 2).
REQ-002 SHALL have ports, one per line (name  direction  width  meaning):
- axis_aclk  in  1  single clock.
- axis_areset  in  1  asynchronous, active-high reset.
- s_axis_tvalid / s_axis_tdata / s_axis_tkeep / s_axis_tlast  in  1 / W_DATA / W_KEEP / 1  stream input from the DUT.
- s_axis_tready  out  1  input-side ready.
- cfg_on_cycles / cfg_off_cycles  in  16 / 16  backpressure pattern.
- rec_valid  out  1  record valid.
- rec_ready  in  1  record ready.
- rec_tdata / rec_tkeep / rec_tlast  out  W_DATA / W_KEEP / 1  captured beat.
- rec_cycle  out  32  cycle stamp of the beat.
- rec_gap  out  16  cycles since the previous accepted beat.
- rec_pkt_idx / rec_beat_idx  out  16 / 16  packet number and beat number within that packet.
- pkt_count  out  32  completed packets.
- err_keep  out  1  sticky keep error.

Function
REQ-003 SHALL accept a beat exactly on cycles where s_axis_tvalid && s_axis_tready.
REQ-004 SHALL drive s_axis_tready = pattern_on && !fifo_full, where fifo_full is registered state; no push occurs when the FIFO is full, even in the same cycle as a pop.
REQ-005 SHALL implement the pattern FSM with states ON and OFF:
- ON counts cfg_on_cycles cycles, then moves to OFF.
- OFF counts cfg_off_cycles cycles, then moves to ON.
- If cfg_off_cycles==0, the FSM stays in ON.
- If cfg_on_cycles==0 and cfg_off_cycles!=0, the FSM stays in OFF.
- Config values are sampled at each state entry.
- pattern_on = (state==ON).
REQ-006 SHALL keep a 32-bit free-running cycle counter that increments every cycle and wraps 0xFFFFFFFF->0.
REQ-007 SHALL stamp rec_cycle with the counter value in the accept cycle.
REQ-008 SHALL set rec_gap = min(cycles since previous accept, 0xFFFF); the first beat after reset records gap 0.
REQ-009 SHALL use a packet FSM with states IDLE and IN_PKT:
- An accept in IDLE assigns beat_idx 0; if tlast=0 the FSM moves to IN_PKT.
- Each accept in IN_PKT increments beat_idx.
- An accept with tlast returns the FSM to IDLE and increments pkt_idx and pkt_count.
- A single-beat packet stays in IDLE.
REQ-010 SHALL wrap pkt_idx and beat_idx mod 2^16; pkt_count SHALL saturate at 0xFFFFFFFF.
REQ-011 SHALL push one record per accepted beat into the FIFO; latency is first-word-fall-through, so rec_valid rises the cycle after the accept.
REQ-012 SHALL hold rec_* stable while rec_valid && !rec_ready; a record is popped on rec_valid && rec_ready.
REQ-013 SHALL allow a simultaneous push and pop when not full, leaving the FIFO count unchanged.

Reset
REQ-014 SHALL, while axis_areset is high, force:
- s_axis_tready=0, rec_valid=0, err_keep=0.
- Counters (cycle, pkt_idx, beat_idx, pkt_count) =0.
- FIFO empty, pattern FSM in ON, packet FSM in IDLE.
REQ-015 SHALL, on reset asserted mid-packet, discard the partial packet without counting it; rec_* data outputs may be X while rec_valid=0.

Configuration
REQ-016 SHALL compile the keep check only under the macro AXIS_CAPTURE_KEEP_CHECK_EN. When defined:
- err_keep sets, and stays set until reset, on an accept whose tkeep is not contiguous from bit 0.
- err_keep also sets on an accept with tkeep==0.
- Non-last beats SHALL additionally require all-ones tkeep.
REQ-017 SHALL, when AXIS_CAPTURE_KEEP_CHECK_EN is undefined, tie err_keep to 0 and include no check logic.

Structure
REQ-018 SHALL place in the shared open_nic_file_tools package: W_DATA/W_KEEP defaults, a capture_rec_t packed struct (tdata, tkeep, tlast, cycle, gap, pkt_idx, beat_idx), and the pattern-state and packet-state enum typedefs.
REQ-019 SHALL instantiate exactly one sub-module, capture_fifo: a synchronous FWFT FIFO of capture_rec_t, depth FIFO_DEPTH, with registered full/empty outputs.

Verification
REQ-020 SHALL be verified by a bench covering these directed scenarios (stimulus -> required response):
- Always ready: cfg 1/0, 3-beat packet with tlast on beat 2, rec_ready=1 -> three records, beat_idx 0,1,2, gap 0,1,1, pkt_count=1.
- Backpressure pattern: cfg 2/3, tvalid held high -> tready pattern 1,1,0,0,0 repeating; records arrive only on the high cycles.
- FIFO full: FIFO_DEPTH=4, rec_ready=0, 6 beats offered -> tready=0 after 4 accepts; each rec_ready pulse admits exactly one more beat.
- Reset mid-packet: reset after beat 1 of a 4-beat packet -> pkt_count=0, rec_valid=0, and the next packet starts at beat_idx 0, pkt_idx 0.
- Keep check (macro defined): non-last beat with tkeep=0x...FFFE -> err_keep=1 next cycle and held; with the macro undefined, the same stimulus -> err_keep=0.
- Gap saturation: 70000 idle cycles between beats -> rec_gap=0xFFFF.
